// File: rtl/gpr_wb_arbiter.sv
// Register-file write-port arbiter: merges in-order pipeline writeback with a buffered
// long-latency return channel, resolving WAW ordering and publishing pending destinations.
module gpr_wb_arbiter #(
  parameter int DEPTH      = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_waddr,
  input  logic [31:0] pipe_wdata,
  input  logic        ext_valid,
  output logic        ext_ready,
  input  logic [4:0]  ext_waddr,
  input  logic [31:0] ext_wdata,
  output logic        we,
  output logic [4:0]  waddr,
  output logic [31:0] wdata,
  output logic [31:0] pend_mask,
  output logic        stall_req
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [SW-1:0] SMAX_C  = SW'(STARVE_MAX);

  logic [4:0]       addr_r [DEPTH];
  logic [31:0]      data_r [DEPTH];
  logic [DEPTH-1:0] live_r;
  logic [PW-1:0]    head_r;
  logic [PW-1:0]    tail_r;
  logic [CW-1:0]    count_r;
  logic [SW-1:0]    starve_r;
  logic             we_r;
  logic [4:0]       waddr_r;
  logic [31:0]      wdata_r;
  logic [31:0]      pend_r;
  logic             stall_r;

  logic             pipe_win_s;
  logic             ext_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             push_live_s;
  logic [DEPTH-1:0] live_n_s;
  logic [4:0]       addr_n_s [DEPTH];
  logic [31:0]      pend_n_s;
  logic [CW-1:0]    count_n_s;
  logic [SW-1:0]    starve_n_s;

  // Next-state computation: arbitration, kill, buffer occupancy and starvation.
  always_comb begin
    pipe_win_s  = pipe_we && (pipe_waddr != 5'd0);
    ext_ready_s = rst && (count_r < DEPTH_C);
    push_s      = ext_valid && ext_ready_s;
    pop_s       = !pipe_win_s && (count_r != '0);
    // The return is older than a same-cycle pipe write to the same register.
    push_live_s = (ext_waddr != 5'd0) && !(pipe_win_s && (ext_waddr == pipe_waddr));
    live_n_s    = live_r;
    for (int i = 0; i < DEPTH; i++) begin
      addr_n_s[i] = addr_r[i];
      if (pipe_win_s && (addr_r[i] == pipe_waddr)) begin
        live_n_s[i] = 1'b0;
      end else begin
        live_n_s[i] = live_r[i];
      end
    end
    if (pop_s) begin
      live_n_s[head_r] = 1'b0;
    end else begin
      live_n_s[head_r] = live_n_s[head_r];
    end
    if (push_s) begin
      live_n_s[tail_r] = push_live_s;
      addr_n_s[tail_r] = ext_waddr;
    end else begin
      live_n_s[tail_r] = live_n_s[tail_r];
    end
    pend_n_s = 32'd0;
    for (int i = 0; i < DEPTH; i++) begin
      if (live_n_s[i]) begin
        pend_n_s = pend_n_s | (32'd1 << addr_n_s[i]);
      end else begin
        pend_n_s = pend_n_s;
      end
    end
    case ({push_s, pop_s})
      2'b10:   count_n_s = count_r + CW'(1'b1);
      2'b01:   count_n_s = count_r - CW'(1'b1);
      default: count_n_s = count_r;
    endcase
    if ((count_r == '0) || pop_s) begin
      starve_n_s = '0;
    end else if (pipe_win_s && (starve_r != SMAX_C)) begin
      starve_n_s = starve_r + SW'(1'b1);
    end else begin
      starve_n_s = starve_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      live_r   <= '0;
      head_r   <= '0;
      tail_r   <= '0;
      count_r  <= '0;
      starve_r <= '0;
      we_r     <= 1'b0;
      waddr_r  <= 5'd0;
      wdata_r  <= 32'd0;
      pend_r   <= 32'd0;
      stall_r  <= 1'b0;
    end else begin
      live_r   <= live_n_s;
      count_r  <= count_n_s;
      starve_r <= starve_n_s;
      pend_r   <= pend_n_s;
      stall_r  <= (starve_n_s == SMAX_C);
      if (push_s) begin
        addr_r[tail_r] <= ext_waddr;
        data_r[tail_r] <= ext_wdata;
        tail_r         <= tail_r + PW'(1'b1);
      end else begin
        tail_r <= tail_r;
      end
      if (pipe_win_s) begin
        we_r    <= 1'b1;
        waddr_r <= pipe_waddr;
        wdata_r <= pipe_wdata;
        head_r  <= head_r;
      end else if (pop_s) begin
        // Killed or r0-targeted entries still drain, spending the slot with we=0.
        we_r    <= live_r[head_r];
        waddr_r <= addr_r[head_r];
        wdata_r <= data_r[head_r];
        head_r  <= head_r + PW'(1'b1);
      end else begin
        we_r    <= 1'b0;
        waddr_r <= waddr_r;
        wdata_r <= wdata_r;
        head_r  <= head_r;
      end
    end
  end

  assign ext_ready = ext_ready_s;
  assign we        = we_r;
  assign waddr     = waddr_r;
  assign wdata     = wdata_r;
  assign pend_mask = pend_r;
  assign stall_req = stall_r;

endmodule

// File: tb/tb_gpr_wb_arbiter.sv
// Vector-table bench for gpr_wb_arbiter: each row's expected post-edge outputs are queued
// when the row is driven and compared after the clock edge.
module tb_gpr_wb_arbiter;

  typedef struct {
    logic        rst;
    logic        pwe;
    logic [4:0]  pa;
    logic [31:0] pd;
    logic        ev;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        xwe;
    logic [4:0]  xwa;
    logic [31:0] xwd;
    logic [31:0] xpend;
    logic        xstall;
    logic        xready;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_waddr;
  logic [31:0] pipe_wdata;
  logic        ext_valid;
  logic        ext_ready;
  logic [4:0]  ext_waddr;
  logic [31:0] ext_wdata;
  logic        we;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] pend_mask;
  logic        stall_req;

  int n_cmp = 0;
  int n_err = 0;
  vec_t vt[$];
  vec_t sb[$];
  logic [31:0] rf [32];
  bit rf0_hit = 1'b0;

  gpr_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
    .ext_valid(ext_valid), .ext_ready(ext_ready), .ext_waddr(ext_waddr), .ext_wdata(ext_wdata),
    .we(we), .waddr(waddr), .wdata(wdata), .pend_mask(pend_mask), .stall_req(stall_req)
  );

  always #5 clk = ~clk;

  // Register file shadow fed only by the DUT write port.
  always @(posedge clk) begin
    if (we) begin
      rf[waddr] <= wdata;
      if (waddr == 5'd0) rf0_hit <= 1'b1;
    end
  end

  function automatic vec_t mk(logic r, logic pwe, logic [4:0] pa, logic [31:0] pd,
                              logic ev, logic [4:0] ea, logic [31:0] ed,
                              logic xwe, logic [4:0] xwa, logic [31:0] xwd,
                              logic [31:0] xpend, logic xstall, logic xready);
    vec_t v;
    v.rst = r; v.pwe = pwe; v.pa = pa; v.pd = pd; v.ev = ev; v.ea = ea; v.ed = ed;
    v.xwe = xwe; v.xwa = xwa; v.xwd = xwd; v.xpend = xpend; v.xstall = xstall; v.xready = xready;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h want %h", nm, row, act, exp);
    end
  endtask

  initial begin
    vec_t v;
    vec_t e;
    rst = 1'b0; pipe_we = 1'b0; pipe_waddr = 5'd0; pipe_wdata = 32'd0;
    ext_valid = 1'b0; ext_waddr = 5'd0; ext_wdata = 32'd0;

    //            rst  pwe  pa     pd          ev   ea     ed         | we  wa     wd          pend          stall ready
    vt.push_back(mk(1'b0,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     32'h0,        1'b0,1'b0));
    vt.push_back(mk(1'b0,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     32'h0,        1'b0,1'b0));
    // pipe write after reset
    vt.push_back(mk(1'b1,1'b1,5'd5, 32'h1234,  1'b0,5'd0, 32'h0,     1'b1,5'd5, 32'h1234,  32'h0,        1'b0,1'b1));
    // single return through empty buffer
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b1,5'd7, 32'hAA,    1'b0,5'd5, 32'h1234,  32'h80,       1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd7, 32'hAA,    32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd7, 32'hAA,    32'h0,        1'b0,1'b1));
    // fill while pipe keeps winning, then starvation
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h900,   1'b1,5'd3, 32'h33,    1'b1,5'd9, 32'h900,   32'h8,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h901,   1'b1,5'd4, 32'h44,    1'b1,5'd9, 32'h901,   32'h18,       1'b0,1'b0));
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h902,   1'b1,5'd5, 32'h55,    1'b1,5'd9, 32'h902,   32'h18,       1'b0,1'b0));
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h903,   1'b0,5'd0, 32'h0,     1'b1,5'd9, 32'h903,   32'h18,       1'b0,1'b0));
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h904,   1'b0,5'd0, 32'h0,     1'b1,5'd9, 32'h904,   32'h18,       1'b1,1'b0));
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h905,   1'b0,5'd0, 32'h0,     1'b1,5'd9, 32'h905,   32'h18,       1'b1,1'b0));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd3, 32'h33,    32'h10,       1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd4, 32'h44,    32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd4, 32'h44,    32'h0,        1'b0,1'b1));
    // WAW kill of a buffered entry
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b1,5'd6, 32'h66,    1'b0,5'd4, 32'h44,    32'h40,       1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b1,5'd6, 32'h55,    1'b0,5'd0, 32'h0,     1'b1,5'd6, 32'h55,    32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd6, 32'h66,    32'h0,        1'b0,1'b1));
    // same-cycle kill of the entry being pushed
    vt.push_back(mk(1'b1,1'b1,5'd8, 32'h800,   1'b1,5'd8, 32'h88,    1'b1,5'd8, 32'h800,   32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd8, 32'h88,    32'h0,        1'b0,1'b1));
    // r0 on both sources
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b1,5'd0, 32'hBB,    1'b0,5'd8, 32'h88,    32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b1,5'd0, 32'hCC,    1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'hBB,    32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b1,5'd0, 32'hDD,    1'b1,5'd2, 32'h22,    1'b0,5'd0, 32'hBB,    32'h4,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b1,5'd0, 32'hDE,    1'b0,5'd0, 32'h0,     1'b1,5'd2, 32'h22,    32'h0,        1'b0,1'b1));
    // simultaneous push and pop, pointer wrap
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b1,5'd10,32'hA0,    1'b0,5'd2, 32'h22,    32'h400,      1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b1,5'd11,32'hB0,    1'b1,5'd10,32'hA0,    32'h800,      1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b1,5'd12,32'hC0,    1'b1,5'd11,32'hB0,    32'h1000,     1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b1,5'd12,32'hC0,    32'h0,        1'b0,1'b1));
    // full buffer, then mid-operation reset
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h910,   1'b1,5'd13,32'hD0,    1'b1,5'd9, 32'h910,   32'h2000,     1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b1,5'd9, 32'h911,   1'b1,5'd14,32'hE0,    1'b1,5'd9, 32'h911,   32'h6000,     1'b0,1'b0));
    vt.push_back(mk(1'b0,1'b1,5'd9, 32'h912,   1'b1,5'd15,32'hF0,    1'b0,5'd0, 32'h0,     32'h0,        1'b0,1'b0));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     32'h0,        1'b0,1'b1));
    vt.push_back(mk(1'b1,1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     1'b0,5'd0, 32'h0,     32'h0,        1'b0,1'b1));

    for (int r = 0; r < vt.size(); r++) begin
      v = vt[r];
      @(negedge clk);
      rst = v.rst; pipe_we = v.pwe; pipe_waddr = v.pa; pipe_wdata = v.pd;
      ext_valid = v.ev; ext_waddr = v.ea; ext_wdata = v.ed;
      sb.push_back(v);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL scoreboard row %0d: got empty queue want one entry", r);
      end else begin
        e = sb.pop_front();
        chk("we",        r, {31'd0, we},        {31'd0, e.xwe});
        chk("waddr",     r, {27'd0, waddr},     {27'd0, e.xwa});
        chk("wdata",     r, wdata,              e.xwd);
        chk("pend_mask", r, pend_mask,          e.xpend);
        chk("stall_req", r, {31'd0, stall_req}, {31'd0, e.xstall});
        chk("ext_ready", r, {31'd0, ext_ready}, {31'd0, e.xready});
      end
    end

    // Architectural register-file contents after the whole sequence.
    chk("rf6_waw",  99, rf[6], 32'h55);
    chk("rf8_waw",  99, rf[8], 32'h800);
    chk("rf2",      99, rf[2], 32'h22);
    chk("rf12",     99, rf[12], 32'hC0);
    chk("rf0_untouched", 99, {31'd0, rf0_hit}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpr_wb_arbiter.md
Name: gpr_wb_arbiter

Overview:
- Writer end of the general-register write port. Merges two write sources onto the register file's single write port (we/waddr/wdata):
  - the in-order pipeline writeback;
  - a long-latency return channel (divider, uncached load) with valid/ready handshake.
- Buffers deferred returns, resolves write-after-write (WAW) ordering against later pipeline writes, and reports pending destinations so the issue logic can stall dependent reads.

Parameters:
- DEPTH, 2, return-buffer entries; power of two, ≥2.
- STARVE_MAX, 4, consecutive lost arbitrations before stall_req asserts.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst=0 resets on the clk edge).
- pipe_we  in  1  pipeline writeback valid.
- pipe_waddr  in  5  pipeline destination register.
- pipe_wdata  in  32  pipeline write data.
- ext_valid  in  1  return-channel request.
- ext_ready  out  1  return channel accepted when ext_valid&&ext_ready.
- ext_waddr  in  5  return destination register.
- ext_wdata  in  32  return data.
- we  out  1  register-file write enable (registered).
- waddr  out  5  register-file write address (registered).
- wdata  out  32  register-file write data (registered).
- pend_mask  out  32  bit i=1: a live buffered write targets register i.
- stall_req  out  1  request that the pipeline freeze writeback for one slot.

Behaviour:
- Reset (rst=0 at an edge):
  - we=0, waddr=0, wdata=0, pend_mask=0, stall_req=0.
  - Buffer empty; starve counter 0.
  - ext_ready=0 while rst=0, and 1 from the first cycle after reset.
- ext_ready: count<DEPTH, combinational from registered count. There is no pass-through when full.
- Push: on ext_valid&&ext_ready, the entry {addr, data, live=1} is appended.
  - ext_waddr==0: the entry is still accepted (the handshake completes) but is stored with live=0.
- Arbitration, evaluated each cycle; the result is registered and appears on we/waddr/wdata at the next edge (1-cycle latency):
  1. pipe_we=1 and pipe_waddr!=0: output the pipe write.
  2. Otherwise, if the buffer is non-empty: pop the head. Output we=live, plus its addr/data.
  3. Otherwise: we=0. waddr/wdata hold their previous values.
  - pipe_we=1 with pipe_waddr=0: treated as no pipe write, so the buffer may pop.
- WAW kill: a winning pipe write to register r clears live on every buffered entry with addr==r.
  - This includes an entry pushed in the same cycle; the ext return is defined as older in program order.
  - Killed entries still pop, consuming one slot with we=0.
- pend_mask:
  - Registered OR over live buffer entries, reflecting post-edge contents (push, pop and kill applied).
  - The output stage is not included; the register file's same-cycle bypass covers it.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) each cycle the buffer is non-empty and the pipe wins.
  - Clears on any pop or when the buffer is empty.
  - stall_req = (counter==STARVE_MAX), registered.
  - Contract: the pipeline drives pipe_we=0 while stall_req=1. If violated, the pipe still wins (no data lost) and the counter stays saturated.
- Simultaneous push and pop in one cycle: count unchanged. Pointers wrap modulo DEPTH.
- Reset mid-operation discards all buffered entries without writing them, and clears we the next cycle.

Test Plan:
- Reset, then pipe_we=1 with addr 5 / data 0x1234 → next cycle we=1, waddr=5, wdata=0x1234; ext_ready=1.
- Buffer empty, pipe idle, ext push addr 7 / data 0xAA → pend_mask=0x80 after edge; pops next cycle; we=1, waddr=7 one cycle later; pend_mask returns to 0.
- Fill buffer (addr 3, 4) with pipe writing addr 9 every cycle → ext_ready=0. Four lost cycles → stall_req=1. Pipe idles → addr 3 then addr 4 written; stall_req=0 after the pop.
- Buffer holds addr 6; pipe writes addr 6 / 0x55 → pend_mask bit6 clears; the later pop yields we=0. The register file ends with 0x55.
- Ext push addr 0 → handshake completes, pend_mask stays 0, pop gives we=0. Pipe_we with addr 0 → no write; the buffer pops instead.
- Buffer full, rst=0 for one cycle → next cycle we=0, pend_mask=0, count=0, stall_req=0; after reset ext_ready=1 and no stale entries are written.
